mmd_divider_ctrl: RTL and testbench
===================================

MMD_DIVIDER_CTRL -- requirements
Module: mmd_divider_ctrl

Interface
REQ-001 Parameter BASE_DIV, default 16, constant part of the division ratio, legal range 0..48.
REQ-002 Port clk  input  1  high-rate input clock; all logic is clocked on its rising edge.
REQ-003 Port rst  input  1  synchronous, active-high reset.
REQ-004 Port en  input  1  run enable; low freezes the divider.
REQ-005 Port n_int  input  4  unsigned integer ratio offset, 0..15.
REQ-006 Port mash_out  input  4  signed two's-complement MASH 1-1-1 sample, -8..+7.
REQ-007 Port tick  output  1  one-cycle strobe at each period boundary; the upstream MASH uses it as its step enable.
REQ-008 Port div_clk  output  1  divided output clock.
REQ-009 Port ratio_q  output  6  ratio N in force for the current period.
REQ-010 Port sat  output  1  asserted together with tick when the loaded ratio was clamped.

Function
REQ-011 Raw ratio SHALL be BASE_DIV + n_int + sign-extended mash_out, computed at signed 8-bit width with no overflow.
REQ-012 Loaded ratio N SHALL be the raw ratio clamped to [MIN_DIV=2, MAX_DIV=63]; sat=1 on that tick iff clamping occurred.
REQ-013 FSM SHALL have two states: IDLE and COUNT.
REQ-014 IDLE with en=1: tick=1, N sampled from the current inputs, ratio_q<=N, cnt<=N-1, next state COUNT.
REQ-015 IDLE with en=0: tick=0, no state change.
REQ-016 COUNT with en=1 and cnt!=0: cnt decrements by 1, tick=0.
REQ-017 COUNT with en=1 and cnt==0: tick=1, new N sampled, ratio_q<=N, cnt<=N-1.
REQ-018 Consecutive ticks SHALL be exactly N cycles apart, where N is the ratio loaded on the first of the two ticks.
REQ-019 mash_out and n_int SHALL be sampled only in tick cycles; changes between ticks have no effect.
REQ-020 COUNT with en=0: next state IDLE, cnt and ratio_q held, tick=0, div_clk<=0.
REQ-021 On re-enable after IDLE, the divider SHALL restart a fresh period (tick in the first en=1 cycle); the residual count is discarded.
REQ-022 A period is the N cycles starting the cycle after a tick.
REQ-023 tick and sat SHALL be registered-state-derived and glitch-free.

Reset
REQ-024 While rst=1: state<=IDLE, cnt<=0, ratio_q<=0, div_clk<=0, tick=0, sat=0; rst overrides en.
REQ-025 A reset asserted mid-period SHALL abort the period; all outputs read 0 in the cycle after the reset edge.

Configuration
REQ-026 Macro MMD_DUTY50_EN:
- Defined: div_clk=1 for the first ceil(N/2) cycles of each period and 0 for the remaining floor(N/2) cycles.
- Undefined: div_clk is tick delayed by one cycle, i.e. high only in the first cycle of each period.
REQ-027 Tick timing, ratio_q and sat SHALL be identical with and without the macro.

Structure
REQ-028 Package mmd_pkg SHALL hold CNT_W=6, MIN_DIV, MAX_DIV and the FSM state enum type.
REQ-029 Sub-module mmd_ratio_sat SHALL perform the REQ-011/012 sum and clamp combinationally, producing N and the clamp flag.

Verification
REQ-030 Run, BASE_DIV=16, n_int=4, mash_out=0, en=1 -> tick every 20 cycles, ratio_q=20, sat=0.
REQ-031 Sequence, mash_out alternating +1/-1 per tick, n_int=4 -> periods 21,19,21,19; ratio_q follows.
REQ-032 Clamping:
- BASE_DIV=0, n_int=0, mash_out=-8 -> ratio_q=2, sat=1, 2-cycle period.
- BASE_DIV=48, n_int=15, mash_out=+7 -> ratio_q=63, sat=1.
REQ-033 Duty cycle, N=5:
- MMD_DUTY50_EN defined -> div_clk pattern 1,1,1,0,0 per period.
- Undefined -> 1,0,0,0,0.
REQ-034 Enable drop, en low for 7 cycles at cycle 8 of a 20-cycle period -> no tick and div_clk=0 while low; tick on the first cycle en is high again; next tick 20 cycles later.
REQ-035 Reset, rst pulsed mid-period -> state IDLE, outputs 0 next cycle; tick in the first cycle with rst=0 and en=1.

Source files
------------

// File: rtl/mmd_divider_ctrl_pkg.sv
// mmd_pkg: shared widths, ratio limits and FSM state type for the MMD divider controller.
package mmd_pkg;

    localparam int CNT_W   = 6;
    localparam int MIN_DIV = 2;
    localparam int MAX_DIV = 63;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } mmd_state_e;

endpackage

// File: rtl/mmd_divider_ctrl_ratio_sat.sv
// mmd_ratio_sat: BASE_DIV + n_int + MASH offset at signed 8-bit width, clamped to [MIN_DIV, MAX_DIV].
module mmd_ratio_sat
    import mmd_pkg::*;
#(
    parameter int BASE_DIV = 16
) (
    input  logic [3:0]       n_int,
    input  logic [3:0]       mash_out,
    output logic [CNT_W-1:0] ratio,
    output logic             clamped
);

    localparam logic signed [7:0] MIN_RAW = 8'(MIN_DIV);
    localparam logic signed [7:0] MAX_RAW = 8'(MAX_DIV);

    logic signed [7:0] raw_s;

    // Sum and saturate; the 8-bit range covers -8..70 without wrapping
    always_comb begin
        raw_s   = 8'(BASE_DIV) + {4'b0000, n_int} + {{4{mash_out[3]}}, mash_out};
        ratio   = CNT_W'(raw_s);
        clamped = 1'b0;
        if (raw_s < MIN_RAW) begin
            ratio   = CNT_W'(MIN_DIV);
            clamped = 1'b1;
        end else if (raw_s > MAX_RAW) begin
            ratio   = CNT_W'(MAX_DIV);
            clamped = 1'b1;
        end else begin
            clamped = 1'b0;
        end
    end

endmodule

// File: rtl/mmd_divider_ctrl.sv
// mmd_divider_ctrl: multi-modulus divider controller; tick marks each N-cycle period boundary.
// Define MMD_DUTY50_EN for a ceil(N/2)-high div_clk; otherwise div_clk is a one-cycle pulse.
module mmd_divider_ctrl
    import mmd_pkg::*;
#(
    parameter int BASE_DIV = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] n_int,
    input  logic [3:0] mash_out,
    output logic       tick,
    output logic       div_clk,
    output logic [5:0] ratio_q,
    output logic       sat
);

    mmd_state_e       state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] ratio_q_r;
    logic [CNT_W-1:0] ratio_s;
    logic             tick_r;
    logic             sat_r;
    logic             div_clk_r;
    logic             clamped_s;
    logic             load_s;
    logic             div_next_s;

    mmd_ratio_sat #(
        .BASE_DIV (BASE_DIV)
    ) u_ratio_sat (
        .n_int    (n_int),
        .mash_out (mash_out),
        .ratio    (ratio_s),
        .clamped  (clamped_s)
    );

    // Period boundary: first enabled cycle out of IDLE, or count exhausted while running
    always_comb begin
        load_s = 1'b0;
        if (en && ((state_r == IDLE) || (cnt_r == CNT_ZERO))) begin
            load_s = 1'b1;
        end else begin
            load_s = 1'b0;
        end
    end

`ifdef MMD_DUTY50_EN
    // High while the remaining count is at least floor(N/2), i.e. the first ceil(N/2) cycles
    always_comb begin
        div_next_s = 1'b0;
        if (en && (state_r == COUNT)) begin
            div_next_s = (cnt_r >= {1'b0, ratio_q_r[CNT_W-1:1]});
        end else begin
            div_next_s = 1'b0;
        end
    end
`else
    // Tick delayed by one cycle, suppressed as soon as the divider is frozen
    always_comb begin
        div_next_s = 1'b0;
        if (en && (state_r == COUNT)) begin
            div_next_s = tick_r;
        end else begin
            div_next_s = 1'b0;
        end
    end
`endif

    // Divider FSM with registered tick, sat, ratio_q and div_clk
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            cnt_r     <= CNT_ZERO;
            ratio_q_r <= CNT_ZERO;
            tick_r    <= 1'b0;
            sat_r     <= 1'b0;
            div_clk_r <= 1'b0;
        end else begin
            div_clk_r <= div_next_s;
            if (load_s) begin
                state_r   <= COUNT;
                cnt_r     <= ratio_s - CNT_ONE;
                ratio_q_r <= ratio_s;
                tick_r    <= 1'b1;
                sat_r     <= clamped_s;
            end else begin
                tick_r <= 1'b0;
                sat_r  <= 1'b0;
                case (state_r)
                    COUNT: begin
                        if (!en) begin
                            state_r <= IDLE;
                        end else begin
                            cnt_r <= cnt_r - CNT_ONE;
                        end
                    end
                    IDLE: begin
                        state_r <= IDLE;
                    end
                    default: begin
                        state_r <= IDLE;
                    end
                endcase
            end
        end
    end

    assign tick    = tick_r;
    assign sat     = sat_r;
    assign div_clk = div_clk_r;
    assign ratio_q = ratio_q_r;

endmodule

// File: tb/tb_mmd_divider_ctrl.sv
// Self-checking bench: three BASE_DIV variants checked every cycle against a period-arithmetic model.
module tb_mmd_divider_ctrl;

    logic       clk_s = 1'b0;
    logic       rst_s;
    logic       en_s;
    logic [3:0] n_int_s;
    logic [3:0] mash_s;
    logic       tick_s    [3];
    logic       div_clk_s [3];
    logic [5:0] ratio_s   [3];
    logic       sat_s     [3];

    int checks = 0;
    int errors = 0;
    int edge_no = 0;
    bit chk_en = 1'b0;

    // Model: each instance remembers when its period started and how long it is
    bit m_run   [3];
    int m_start [3];
    int m_n     [3];
    bit x_tick  [3];
    bit x_div   [3];
    bit x_sat   [3];
    int x_ratio [3];

    typedef struct {
        logic [3:0] n_int;
        logic [3:0] mash;
        int         r16;
        bit         s16;
        int         r0;
        bit         s0;
        int         r48;
        bit         s48;
    } vec_t;

    vec_t tab [8];

    always #5 clk_s = ~clk_s;

    mmd_divider_ctrl #(.BASE_DIV(16)) u_dut_b16 (
        .clk(clk_s), .rst(rst_s), .en(en_s), .n_int(n_int_s), .mash_out(mash_s),
        .tick(tick_s[0]), .div_clk(div_clk_s[0]), .ratio_q(ratio_s[0]), .sat(sat_s[0])
    );
    mmd_divider_ctrl #(.BASE_DIV(0)) u_dut_b0 (
        .clk(clk_s), .rst(rst_s), .en(en_s), .n_int(n_int_s), .mash_out(mash_s),
        .tick(tick_s[1]), .div_clk(div_clk_s[1]), .ratio_q(ratio_s[1]), .sat(sat_s[1])
    );
    mmd_divider_ctrl #(.BASE_DIV(48)) u_dut_b48 (
        .clk(clk_s), .rst(rst_s), .en(en_s), .n_int(n_int_s), .mash_out(mash_s),
        .tick(tick_s[2]), .div_clk(div_clk_s[2]), .ratio_q(ratio_s[2]), .sat(sat_s[2])
    );

    function automatic int base_of(input int i);
        case (i)
            0:       return 16;
            1:       return 0;
            default: return 48;
        endcase
    endfunction

    function automatic int clamp_ratio(input int raw);
        if (raw < 2) return 2;
        if (raw > 63) return 63;
        return raw;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_no);
        end
    endtask

    task automatic model_edge();
        int raw;
        int j;
        edge_no++;
        for (int i = 0; i < 3; i++) begin
            x_tick[i] = 1'b0;
            x_sat[i]  = 1'b0;
            x_div[i]  = 1'b0;
            if (rst_s) begin
                m_run[i]   = 1'b0;
                x_ratio[i] = 0;
            end else if (!en_s) begin
                m_run[i] = 1'b0;
            end else begin
                if (!m_run[i] || (edge_no == m_start[i] + m_n[i])) begin
                    raw        = base_of(i) + int'(n_int_s) + int'($signed(mash_s));
                    m_n[i]     = clamp_ratio(raw);
                    x_tick[i]  = 1'b1;
                    x_sat[i]   = (raw != m_n[i]);
                    x_ratio[i] = m_n[i];
                    m_run[i]   = 1'b1;
                    m_start[i] = edge_no;
                end
                j = edge_no - m_start[i];
`ifdef MMD_DUTY50_EN
                x_div[i] = (j >= 1) && (j <= (m_n[i] + 1) / 2);
`else
                x_div[i] = (j == 1);
`endif
            end
        end
    endtask

    task automatic step();
        @(posedge clk_s);
        model_edge();
        #1;
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                check($sformatf("tick[%0d]", i), 32'(tick_s[i]), 32'(x_tick[i]));
                check($sformatf("div_clk[%0d]", i), 32'(div_clk_s[i]), 32'(x_div[i]));
                check($sformatf("ratio_q[%0d]", i), 32'(ratio_s[i]), 32'(x_ratio[i]));
                check($sformatf("sat[%0d]", i), 32'(sat_s[i]), 32'(x_sat[i]));
            end
        end
    endtask

    task automatic wait_tick(input int inst, input int limit, output int at);
        at = -1;
        for (int k = 0; k < limit; k++) begin
            step();
            if (tick_s[inst] === 1'b1) begin
                at = edge_no;
                break;
            end
        end
        check($sformatf("wait_tick[%0d]", inst), 32'(at >= 0), 32'd1);
    endtask

    task automatic do_reset();
        rst_s = 1'b1;
        step();
        rst_s = 1'b0;
    endtask

    initial begin
        int t0;
        int t1;
        int t2;
        logic [4:0] pat;

        tab[0] = '{4'd4,  4'd0, 20, 1'b0,  4, 1'b0, 52, 1'b0};
        tab[1] = '{4'd0,  4'h8,  8, 1'b0,  2, 1'b1, 40, 1'b0};
        tab[2] = '{4'd15, 4'd7, 38, 1'b0, 22, 1'b0, 63, 1'b1};
        tab[3] = '{4'd15, 4'd0, 31, 1'b0, 15, 1'b0, 63, 1'b0};
        tab[4] = '{4'd15, 4'd1, 32, 1'b0, 16, 1'b0, 63, 1'b1};
        tab[5] = '{4'd1,  4'd0, 17, 1'b0,  2, 1'b1, 49, 1'b0};
        tab[6] = '{4'd2,  4'd0, 18, 1'b0,  2, 1'b0, 50, 1'b0};
        tab[7] = '{4'd0,  4'hF, 15, 1'b0,  2, 1'b1, 47, 1'b0};

        // Reset dominates en
        rst_s = 1'b1; en_s = 1'b1; n_int_s = 4'd4; mash_s = 4'd0;
        step();
        chk_en = 1'b1;
        step();
        step();
        for (int i = 0; i < 3; i++) begin
            check("rst_tick", 32'(tick_s[i]), 32'd0);
            check("rst_div_clk", 32'(div_clk_s[i]), 32'd0);
            check("rst_ratio_q", 32'(ratio_s[i]), 32'd0);
            check("rst_sat", 32'(sat_s[i]), 32'd0);
        end

        // Ratio sum and clamp table: first tick after reset loads the vector
        for (int v = 0; v < 8; v++) begin
            rst_s = 1'b1;
            step();
            rst_s = 1'b0; en_s = 1'b1; n_int_s = tab[v].n_int; mash_s = tab[v].mash;
            step();
            check("tab_tick16", 32'(tick_s[0]), 32'd1);
            check("tab_ratio16", 32'(ratio_s[0]), 32'(tab[v].r16));
            check("tab_sat16", 32'(sat_s[0]), 32'(tab[v].s16));
            check("tab_ratio0", 32'(ratio_s[1]), 32'(tab[v].r0));
            check("tab_sat0", 32'(sat_s[1]), 32'(tab[v].s0));
            check("tab_ratio48", 32'(ratio_s[2]), 32'(tab[v].r48));
            check("tab_sat48", 32'(sat_s[2]), 32'(tab[v].s48));
        end

        // Steady run with ratio 20
        n_int_s = 4'd4; mash_s = 4'd0; en_s = 1'b1;
        do_reset();
        wait_tick(0, 5, t0);
        wait_tick(0, 30, t1);
        check("run_gap1", 32'(t1 - t0), 32'd20);
        wait_tick(0, 30, t2);
        check("run_gap2", 32'(t2 - t1), 32'd20);
        check("run_ratio", 32'(ratio_s[0]), 32'd20);

        // Alternating MASH sample per tick
        mash_s = 4'd1;
        do_reset();
        wait_tick(0, 5, t0);
        for (int k = 0; k < 4; k++) begin
            mash_s = (k % 2 == 0) ? 4'hF : 4'd1;
            wait_tick(0, 40, t1);
            check("alt_gap", 32'(t1 - t0), (k % 2 == 0) ? 32'd21 : 32'd19);
            check("alt_ratio", 32'(ratio_s[0]), (k % 2 == 0) ? 32'd19 : 32'd21);
            t0 = t1;
        end

        // Minimum clamp gives a 2-cycle period
        n_int_s = 4'd0; mash_s = 4'h8;
        do_reset();
        wait_tick(1, 5, t0);
        wait_tick(1, 5, t1);
        check("min_gap", 32'(t1 - t0), 32'd2);
        check("min_sat", 32'(sat_s[1]), 32'd1);

        // Duty pattern at N=5
        n_int_s = 4'd5; mash_s = 4'd0;
        do_reset();
        wait_tick(1, 5, t0);
        pat = 5'b00000;
        for (int k = 0; k < 5; k++) begin
            step();
            pat = {pat[3:0], div_clk_s[1]};
        end
`ifdef MMD_DUTY50_EN
        check("duty_pattern", 32'(pat), 32'(5'b11100));
`else
        check("duty_pattern", 32'(pat), 32'(5'b10000));
`endif
        check("duty_ratio", 32'(ratio_s[1]), 32'd5);

        // Enable dropped for 7 cycles mid-period
        n_int_s = 4'd4; mash_s = 4'd0;
        do_reset();
        wait_tick(0, 5, t0);
        for (int k = 0; k < 7; k++) step();
        en_s = 1'b0;
        for (int k = 0; k < 7; k++) begin
            step();
            check("frozen_tick", 32'(tick_s[0]), 32'd0);
            check("frozen_div_clk", 32'(div_clk_s[0]), 32'd0);
            check("frozen_ratio", 32'(ratio_s[0]), 32'd20);
        end
        en_s = 1'b1;
        step();
        check("reenable_tick", 32'(tick_s[0]), 32'd1);
        t1 = edge_no;
        wait_tick(0, 30, t2);
        check("reenable_gap", 32'(t2 - t1), 32'd20);

        // Reset mid-period
        for (int k = 0; k < 5; k++) step();
        rst_s = 1'b1;
        step();
        check("midrst_tick", 32'(tick_s[0]), 32'd0);
        check("midrst_ratio", 32'(ratio_s[0]), 32'd0);
        check("midrst_div_clk", 32'(div_clk_s[0]), 32'd0);
        rst_s = 1'b0;
        step();
        check("postrst_tick", 32'(tick_s[0]), 32'd1);

        // Random traffic; inputs wiggle every cycle but matter only on ticks
        for (int k = 0; k < 4000; k++) begin
            rst_s   = ($urandom_range(0, 199) == 0);
            en_s    = ($urandom_range(0, 79) != 0);
            n_int_s = 4'($urandom);
            mash_s  = 4'($urandom);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
